axis_ask_uart_rx_wrapper: RTL and testbench



---
 rtl/axis_ask_uart_rx_wrapper.sv | 144 ++++++++++++++
 tb/tb_axis_ask_uart_rx_wrapper.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/axis_ask_uart_rx_wrapper.sv
// ASK envelope slicer + 8N1 UART receiver feeding a first-word-fall-through
// byte FIFO, presented as an 8-bit AXI Stream master.
module axis_ask_uart_rx_wrapper #(
  parameter int ASK_RX_LENGTH = 2,
  parameter int ASK_THRESHOLD = 2**(ASK_RX_LENGTH-1),
  parameter int RX_SIZE       = 16,
  parameter int CLKDIV_RX     = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ASK_RX_LENGTH-1:0] ask_rx,
  output logic [7:0]               o_tdata,
  output logic                     o_tvalid,
  input  logic                     o_tready,
  output logic [15:0]              fifo_level,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int CNT_W = $clog2(CLKDIV_RX);
  localparam int PTR_W = $clog2(RX_SIZE);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [ASK_RX_LENGTH-1:0] THR      = ASK_RX_LENGTH'(ASK_THRESHOLD);
  localparam logic [CNT_W-1:0]         CNT_FULL = CNT_W'(CLKDIV_RX - 1);
  localparam logic [CNT_W-1:0]         CNT_HALF = CNT_W'(CLKDIV_RX/2 - 1);
  localparam logic [LVL_W-1:0]         LVL_MAX  = LVL_W'(RX_SIZE);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t                     state_q, state_d;
  logic [ASK_RX_LENGTH-1:0]   ask_q;
  logic                       rx_d_q, rx_d_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [2:0]                 bitidx_q, bitidx_d;
  logic [7:0]                 shreg_q, shreg_d;
  logic                       frame_err_q, frame_err_d;
  logic                       overrun_q, overrun_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]           level_q, level_d;
  logic [7:0]                 mem [RX_SIZE];

  logic rx_bit, start_det, push, pop;

  always_comb begin
    rx_bit      = (ask_q >= THR);
    rx_d_d      = rx_bit;
    // rx_d resets low, so a line already low at reset never looks like a start
    start_det   = rx_d_q && !rx_bit;
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitidx_d    = bitidx_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_det) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end
      START: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else if (!rx_bit) begin
          state_d  = DATA;
          cnt_d    = CNT_FULL;
          bitidx_d = 3'd0;
        end else state_d = IDLE;
      end
      DATA: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else begin
          shreg_d  = {rx_bit, shreg_q[7:1]};
          cnt_d    = CNT_FULL;
          bitidx_d = bitidx_q + 3'd1;
          if (bitidx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else if (rx_bit) begin
          // Fullness is judged on the pre-pop level
          if (level_q < LVL_MAX) push = 1'b1;
          else overrun_d = 1'b1;
          state_d = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rx_bit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    pop      = (level_q != '0) && o_tready;
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ask_q       <= '0;
      rx_d_q      <= 1'b0;
      cnt_q       <= '0;
      bitidx_q    <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
    end else begin
      state_q     <= state_d;
      ask_q       <= ask_rx;
      rx_d_q      <= rx_d_d;
      cnt_q       <= cnt_d;
      bitidx_q    <= bitidx_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr_q] <= shreg_q;
  end

  // Head entry is masked while empty so o_tdata reads 0 out of reset
  assign o_tvalid   = (level_q != '0);
  assign o_tdata    = o_tvalid ? mem[rd_ptr_q] : 8'h00;
  assign fifo_level = 16'(level_q);
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_axis_ask_uart_rx_wrapper.sv
// Directed bench for axis_ask_uart_rx_wrapper: clean frames, framing error,
// glitch rejection, FIFO saturation/overrun and mid-frame reset.
module tb_axis_ask_uart_rx_wrapper;
  localparam int CLKDIV = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ask_rx = 2'd3;
  logic        o_tready = 1'b1;
  logic [7:0]  o_tdata;
  logic        o_tvalid;
  logic [15:0] fifo_level;
  logic        frame_err, overrun;

  axis_ask_uart_rx_wrapper #(
    .ASK_RX_LENGTH(2), .ASK_THRESHOLD(2), .RX_SIZE(16), .CLKDIV_RX(CLKDIV)
  ) dut (
    .clk(clk), .rst(rst), .ask_rx(ask_rx),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .fifo_level(fifo_level), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int pcnt = 0;
  always @(posedge clk) pcnt <= pcnt + 1;

  int ncmp = 0, nerr = 0;
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, lvl_max = 0, rise_pc = 0;
  logic tv_seen = 1'b0;
  logic [7:0] rxq[$];

  // Observe on the falling edge; stimulus changes 1 time unit after rising edges
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (frame_err && overrun) both_cnt++;
    if (o_tvalid && o_tready && !rst) rxq.push_back(o_tdata);
    if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
    if (o_tvalid && !tv_seen) begin
      tv_seen = 1'b1;
      rise_pc = pcnt;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic line(input logic v, input int n);
    ask_rx = v ? 2'd3 : 2'd0;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    line(1'b0, CLKDIV);
    for (int i = 0; i < 8; i++) line(b[i], CLKDIV);
    line(stop, CLKDIV);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qpop();
    if (rxq.size() == 0) return 32'hdead_beef;
    return {24'h0, rxq.pop_front()};
  endfunction

  initial begin
    int p;
    // Reset state
    repeat (3) tick();
    chk("rst_tvalid", o_tvalid, 0);
    chk("rst_tdata", o_tdata, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b0;
    line(1'b1, 20);

    // 1: clean 0xA5, check o_tvalid rise at T+951
    tv_seen = 1'b0;
    p = pcnt;
    send_frame(8'hA5, 1'b1);
    line(1'b1, 50);
    chk("t1_rise", rise_pc - (p + 1), 951);
    chk("t1_byte", qpop(), 8'hA5);
    chk("t1_count", rxq.size(), 0);
    chk("t1_ferr", fe_cnt, 0);
    chk("t1_ovr", ov_cnt, 0);

    // 2: back-to-back frames
    lvl_max = 0;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    line(1'b1, 50);
    chk("t2_b0", qpop(), 8'h00);
    chk("t2_b1", qpop(), 8'hFF);
    chk("t2_b2", qpop(), 8'h55);
    chk("t2_count", rxq.size(), 0);
    chk("t2_lvlmax", lvl_max, 1);

    // 3: bad stop bit, line held low, then good frame
    send_frame(8'h3C, 1'b0);
    line(1'b0, 200);
    chk("t3_ferr_once", fe_cnt, 1);
    chk("t3_nobeat", rxq.size(), 0);
    line(1'b1, 100);
    send_frame(8'h81, 1'b1);
    line(1'b1, 50);
    chk("t3_ferr_total", fe_cnt, 1);
    chk("t3_ovr", ov_cnt, 0);
    chk("t3_byte", qpop(), 8'h81);
    chk("t3_count", rxq.size(), 0);

    // 4: short low glitch is rejected
    line(1'b0, 30);
    line(1'b1, 200);
    chk("t4_nobeat", rxq.size(), 0);
    chk("t4_level", fifo_level, 0);
    chk("t4_ferr", fe_cnt, 1);
    chk("t4_ovr", ov_cnt, 0);
    send_frame(8'h5A, 1'b1);
    line(1'b1, 50);
    chk("t4_after", qpop(), 8'h5A);

    // 5: saturate FIFO with tready low, overrun on 17th byte, then drain
    o_tready = 1'b0;
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
    line(1'b1, 20);
    chk("t5_level16", fifo_level, 16);
    chk("t5_ovr_before", ov_cnt, 0);
    chk("t5_tvalid", o_tvalid, 1);
    chk("t5_head", o_tdata, 8'h00);
    send_frame(8'h10, 1'b1);
    line(1'b1, 20);
    chk("t5_ovr", ov_cnt, 1);
    chk("t5_level_sat", fifo_level, 16);
    chk("t5_head_stable", o_tdata, 8'h00);
    o_tready = 1'b1;
    line(1'b1, 40);
    chk("t5_level0", fifo_level, 0);
    chk("t5_tvalid0", o_tvalid, 0);
    chk("t5_count", rxq.size(), 16);
    for (int i = 0; i < 16; i++) chk("t5_drain", qpop(), i);
    chk("t5_ferr", fe_cnt, 1);

    // 6: reset mid-DATA of 0x77 with line low; FIFO holds a byte beforehand
    o_tready = 1'b0;
    send_frame(8'h99, 1'b1);
    line(1'b1, 20);
    chk("t6_prefill", fifo_level, 1);
    line(1'b0, CLKDIV);
    line(1'b1, 3*CLKDIV);
    line(1'b0, 50);
    rst = 1'b1;
    tick();
    chk("t6_tvalid", o_tvalid, 0);
    chk("t6_tdata", o_tdata, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_ferr", frame_err, 0);
    chk("t6_ovr", overrun, 0);
    rst = 1'b0;
    line(1'b0, 300);
    line(1'b1, 100);
    chk("t6_nobyte", fifo_level, 0);
    chk("t6_noferr", fe_cnt, 1);
    o_tready = 1'b1;
    send_frame(8'h42, 1'b1);
    line(1'b1, 50);
    chk("t6_byte", qpop(), 8'h42);
    chk("t6_count", rxq.size(), 0);
    chk("t6_ovr_total", ov_cnt, 1);
    chk("both_pulses", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
